// File: rtl/wb_backdoor_pkg.sv
// Shared definitions for the Wishbone backdoor crossbar: address spaces, FSM states, CSR map.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wb_backdoor_pkg;

   // Address space selected by wb_addr_i[17:16]
   typedef enum logic [1:0] {
      SP_ROM  = 2'd0,
      SP_RAM  = 2'd1,
      SP_CSR  = 2'd2,
      SP_NONE = 2'd3
   } space_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_e;

   // CSR word offsets (wb_addr_i[3:2])
   localparam logic [1:0] CSR_CTRL = 2'd0;
   localparam logic [1:0] CSR_STAT = 2'd1;

   // Status/control bit positions
   localparam int STAT_HOLD     = 0;
   localparam int STAT_HOLD_ACK = 1;
   localparam int STAT_TIMEOUT  = 2;
   localparam int STAT_ERRC_LSB = 8;

endpackage

// File: rtl/wb_backdoor_csr.sv
// CSR block: CPU hold bit, saturating error counter, sticky timeout flag, read mux.
// Latency: writes take effect on the next clock; read data is combinational from i_off.
// Backpressure: none; accesses are single-cycle and always accepted.
// Ports: i_wr/i_off/i_wbit write a CSR word; i_err counts one error per cycle;
//        i_timeout sets the sticky flag; i_hold_ack is reported live; o_hold drives the CPU stall.
module wb_backdoor_csr
   import wb_backdoor_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        i_wr,
   input  logic [1:0]  i_off,
   input  logic        i_wbit,
   input  logic        i_err,
   input  logic        i_timeout,
   input  logic        i_hold_ack,
   output logic        o_hold,
   output logic [31:0] o_rdat
);

   logic [7:0] r_err_count;
   logic       r_timeout_flag;
   logic       r_hold;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_err_count    <= 8'd0;
         r_timeout_flag <= 1'b0;
         r_hold         <= 1'b0;
      end else begin
         if (i_wr && i_off == CSR_CTRL) begin
            r_hold <= i_wbit;
         end
         // A status write and an error/timeout event never coincide: CSR writes
         // are taken in IDLE, errors and timeouts come out of ISSUE/RESP.
         if (i_wr && i_off == CSR_STAT) begin
            r_err_count    <= 8'd0;
            r_timeout_flag <= 1'b0;
         end else begin
            if (i_err && r_err_count != 8'hFF) begin
               r_err_count <= r_err_count + 8'd1;
            end
            if (i_timeout) begin
               r_timeout_flag <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      o_rdat = '0;
      case (i_off)
         CSR_CTRL: o_rdat[STAT_HOLD] = r_hold;
         CSR_STAT: begin
            o_rdat[STAT_HOLD]              = r_hold;
            o_rdat[STAT_HOLD_ACK]          = i_hold_ack;
            o_rdat[STAT_TIMEOUT]           = r_timeout_flag;
            o_rdat[STAT_ERRC_LSB +: 8]     = r_err_count;
         end
         default: o_rdat = '0;
      endcase
   end

   assign o_hold = r_hold;

endmodule

// File: rtl/wb_backdoor_xbar.sv
// Routes a Wishbone classic host port to ROM/RAM backdoor ports plus a small CSR space.
// Latency: target ack in first ISSUE cycle -> host ack 2 cycles after stb; CSR/unmapped 1; timeout TIMEOUT+1.
// Backpressure: new requests only sampled in IDLE; host waits on ack/err; dropping cyc aborts ISSUE.
// Ports: wb_* host slave; tgt_* latched address/data/we/cyc shared by all targets;
//        rom_*/ram_* per-port strobes, packed read data and acks; cpu_hold_o/cpu_hold_ack_i CPU stall handshake.
module wb_backdoor_xbar
   import wb_backdoor_pkg::*;
#(
   parameter int NUM_ROMS    = 1,
   parameter int NUM_RAMS    = 2,
   parameter int ROM_SEL_LSB = 10,
   parameter int RAM_SEL_LSB = 9,
   parameter int TIMEOUT     = 15,
   parameter int ROM_WP      = 1
)(
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [31:0]              wb_data_i,
   input  logic [31:0]              wb_addr_i,
   input  logic                     wb_cyc_i,
   input  logic                     wb_strobe_i,
   input  logic                     wb_we_i,
   output logic [31:0]              wb_data_o,
   output logic                     wb_ack_o,
   output logic                     wb_err_o,
   output logic [31:0]              tgt_addr_o,
   output logic [31:0]              tgt_data_o,
   output logic                     tgt_we_o,
   output logic                     tgt_cyc_o,
   output logic [NUM_ROMS-1:0]      rom_strobe_o,
   input  logic [32*NUM_ROMS-1:0]   rom_data_i,
   input  logic [NUM_ROMS-1:0]      rom_ack_i,
   output logic [NUM_RAMS-1:0]      ram_strobe_o,
   input  logic [32*NUM_RAMS-1:0]   ram_data_i,
   input  logic [NUM_RAMS-1:0]      ram_ack_i,
   output logic                     cpu_hold_o,
   input  logic                     cpu_hold_ack_i
);

   localparam logic [4:0] L_NROM     = 5'(NUM_ROMS);
   localparam logic [4:0] L_NRAM     = 5'(NUM_RAMS);
   localparam logic [7:0] L_TMO_LAST = 8'(TIMEOUT - 1);

   state_e      r_state;
   space_e      r_space;
   logic [3:0]  r_idx;
   logic [7:0]  r_timer;
   logic [31:0] r_addr, r_wdat, r_rdata;
   logic        r_we, r_ack, r_err;

   space_e      w_space;
   logic [3:0]  w_idx;
   logic        w_req, w_mapped, w_protect, w_issue, w_sel_ack, w_timeout, w_hold, w_csr_wr;
   logic [31:0] w_sel_dat, w_csr_rdat;

   assign w_req   = wb_cyc_i && wb_strobe_i;
   assign w_space = space_e'(wb_addr_i[17:16]);
   assign w_idx   = (w_space == SP_ROM) ? wb_addr_i[ROM_SEL_LSB +: 4] : wb_addr_i[RAM_SEL_LSB +: 4];

   always_comb begin
      w_mapped = 1'b0;
      case (w_space)
         SP_ROM:  w_mapped = {1'b0, w_idx} < L_NROM;
         SP_RAM:  w_mapped = {1'b0, w_idx} < L_NRAM;
         default: w_mapped = 1'b0;
      endcase
   end

   // ROM images may only be patched while the CPU is held off them.
   assign w_protect = (w_space == SP_ROM) && wb_we_i && (ROM_WP != 0) && !w_hold;

   // Gating with cyc makes an abort drop strobes in the same cycle, before the FSM leaves ISSUE.
   assign w_issue   = (r_state == ST_ISSUE) && wb_cyc_i;
   assign w_timeout = w_issue && !w_sel_ack && (r_timer == L_TMO_LAST);
   assign w_csr_wr  = (r_state == ST_IDLE) && w_req && (w_space == SP_CSR) && wb_we_i;

   // One-hot strobe and ack/data select for the latched target; other ports' acks are ignored.
   always_comb begin
      rom_strobe_o = '0;
      ram_strobe_o = '0;
      w_sel_ack    = 1'b0;
      w_sel_dat    = '0;
      for (int k = 0; k < NUM_ROMS; k++) begin
         if (r_space == SP_ROM && r_idx == 4'(k)) begin
            rom_strobe_o[k] = w_issue;
            w_sel_ack       = w_sel_ack | rom_ack_i[k];
            w_sel_dat       = w_sel_dat | rom_data_i[32*k +: 32];
         end
      end
      for (int k = 0; k < NUM_RAMS; k++) begin
         if (r_space == SP_RAM && r_idx == 4'(k)) begin
            ram_strobe_o[k] = w_issue;
            w_sel_ack       = w_sel_ack | ram_ack_i[k];
            w_sel_dat       = w_sel_dat | ram_data_i[32*k +: 32];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_space <= SP_ROM;
         r_idx   <= 4'd0;
         r_timer <= 8'd0;
         r_addr  <= 32'd0;
         r_wdat  <= 32'd0;
         r_we    <= 1'b0;
         r_rdata <= 32'd0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  r_addr  <= wb_addr_i;
                  r_wdat  <= wb_data_i;
                  r_we    <= wb_we_i;
                  r_space <= w_space;
                  r_idx   <= w_idx;
                  if (w_space == SP_CSR) begin
                     r_state <= ST_RESP;
                     r_ack   <= 1'b1;
                     r_rdata <= wb_we_i ? 32'd0 : w_csr_rdat;
                  end else if (!w_mapped || w_protect) begin
                     r_state <= ST_RESP;
                     r_err   <= 1'b1;
                     r_rdata <= 32'd0;
                  end else begin
                     r_state <= ST_ISSUE;
                     r_timer <= 8'd0;
                  end
               end
            end
            ST_ISSUE: begin
               if (!wb_cyc_i) begin
                  r_state <= ST_IDLE;
               end else if (w_sel_ack) begin
                  r_state <= ST_RESP;
                  r_ack   <= 1'b1;
                  r_rdata <= r_we ? 32'd0 : w_sel_dat;
               end else if (r_timer == L_TMO_LAST) begin
                  r_state <= ST_RESP;
                  r_err   <= 1'b1;
                  r_rdata <= 32'd0;
               end else begin
                  r_timer <= r_timer + 8'd1;
               end
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   wb_backdoor_csr u_csr (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_wr       (w_csr_wr),
      .i_off      (wb_addr_i[3:2]),
      .i_wbit     (wb_data_i[0]),
      .i_err      (r_err),
      .i_timeout  (w_timeout),
      .i_hold_ack (cpu_hold_ack_i),
      .o_hold     (w_hold),
      .o_rdat     (w_csr_rdat)
   );

   assign wb_data_o  = r_rdata;
   assign wb_ack_o   = r_ack;
   assign wb_err_o   = r_err;
   assign tgt_addr_o = r_addr;
   assign tgt_data_o = r_wdat;
   assign tgt_we_o   = r_we;
   assign tgt_cyc_o  = w_issue;
   assign cpu_hold_o = w_hold;

endmodule
